// File: rtl/uart_rx_stream_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_stream_pkg
// Shared definitions for the UART receive stream block:
//   - rx_state_e    : receiver FSM states
//   - clog2()       : ceiling log2 for sizing counters and pointers
//   - clks_per_bit(): system clocks per UART bit (integer division)
//   - half_bit()    : clocks from start-edge detection to mid start bit
// -----------------------------------------------------------------------------
package uart_rx_stream_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } rx_state_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
      return clock_frequency / baud_rate;
   endfunction

   function automatic int half_bit(input int clock_frequency, input int baud_rate);
      return clks_per_bit(clock_frequency, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// -----------------------------------------------------------------------------
// uart_rx_stream_if
// Byte stream carried on a stb/ack handshake, byte zero-extended to 32 bits.
//   output_rx     : data word, byte in [7:0], [31:8] = 0
//   output_rx_stb : data word valid
//   output_rx_ack : consumer accepts the word this cycle
// Modports: master = producer (receiver), slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_stream_if;

   logic [31:0] output_rx;
   logic        output_rx_stb;
   logic        output_rx_ack;

   modport master (
      output output_rx,
      output output_rx_stb,
      input  output_rx_ack
   );

   modport slave (
      input  output_rx,
      input  output_rx_stb,
      output output_rx_ack
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word fall-through byte FIFO. The head entry is visible on o_head
// whenever o_empty is low; a pop simply advances the read pointer.
//   clk, rst : system clock, asynchronous active-high reset
//   i_push   : write i_data (ignored when full unless popping this cycle)
//   i_data   : byte to write
//   i_pop    : remove head entry (ignored when empty)
//   o_head   : current head entry
//   o_full   : FIFO holds DEPTH entries
//   o_empty  : FIFO holds no entries
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_rx_stream_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_head,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = clog2(DEPTH);

   // One extra pointer bit separates the full and empty cases when the
   // address bits match.
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [7:0]    r_mem [DEPTH];

   logic          w_do_pop;
   logic          w_do_push;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   // When full, the slot being written is the one being popped this cycle,
   // so a simultaneous pop frees room for the push.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only ever read
   // after it has been written, and leaving it out of reset keeps it RAM-able.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_rx_stream.sv
// -----------------------------------------------------------------------------
// uart_rx_stream
// 8N1 UART receiver feeding a FWFT byte FIFO presented as a stb/ack stream.
//   clk           : system clock
//   rst           : asynchronous reset, active-high
//   rx            : UART line, idle high, asynchronous to clk
//   stream        : stb/ack byte stream (master side)
//   framing_error : one-cycle pulse, stop bit sampled low
//   overrun       : one-cycle pulse, valid byte dropped because FIFO full
// -----------------------------------------------------------------------------
module uart_rx_stream
   import uart_rx_stream_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 100000000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   uart_rx_stream_if.master  stream,
   output logic              framing_error,
   output logic              overrun
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int HALF_BIT     = half_bit(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int CNT_W        = clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

   logic [1:0]       r_sync;
   logic             w_rx_s;

   rx_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;

   logic             w_push;
   logic             w_pop;
   logic [7:0]       w_head;
   logic             w_full;
   logic             w_empty;

   // Two-flop synchroniser, reset to the idle line level so reset release
   // never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], rx};
   end

   assign w_rx_s = r_sync[1];

   // NOTE: every register here is assigned with <= so all branches see the
   // pre-edge values of state, counter and shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         framing_error <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end

            // Re-check the line at mid start bit; a short low glitch returns
            // to IDLE silently.
            S_START: begin
               if (r_cnt == CNT_HALF_END) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= w_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // LSB arrives first, so shift right and insert at bit 7.
            S_DATA: begin
               if (r_cnt == CNT_BIT_END) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx_s, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
                  else                   r_bit_idx <= r_bit_idx + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (r_cnt == CNT_BIT_END) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     r_state <= S_IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     r_state       <= S_WAIT_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // A held break must return high before another frame can start.
            S_WAIT_IDLE: begin
               if (w_rx_s) r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The byte is written on the same edge that ends the stop bit, so it is
   // visible on the stream one cycle after the stop sample.
   assign w_push = (r_state == S_STOP) && (r_cnt == CNT_BIT_END) && w_rx_s;
   assign w_pop  = stream.output_rx_ack && !w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun <= 1'b0;
      else     overrun <= w_push && w_full && !w_pop;
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (r_shift),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Data is forced to zero when nothing is queued so the unwritten FIFO
   // storage never leaks onto the bus.
   assign stream.output_rx_stb = !w_empty;
   assign stream.output_rx     = w_empty ? 32'd0 : {24'd0, w_head};

endmodule

// File: tb/tb_uart_rx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_stream
// Directed stimulus for uart_rx_stream at 16 clocks per bit, FIFO depth 4.
// A frame-level model (expected byte queue plus error counters) is updated
// as each frame's stop bit is driven; a per-cycle monitor checks the stream
// against it, and literal expectations pin latency, pulse counts and order.
// -----------------------------------------------------------------------------
module tb_uart_rx_stream;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic framing_error;
   logic overrun;

   uart_rx_stream_if sif ();

   uart_rx_stream #(
      .CLOCK_FREQUENCY (16),
      .BAUD_RATE       (1),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .stream        (sif),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level model state
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int exp_fe = 0;
   int exp_ov = 0;
   int obs_fe = 0;
   int obs_ov = 0;
   int stb_cycles = 0;
   int start_cyc = 0;
   int last_ov_cyc = 0;
   bit latency_armed = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Model update at the point a frame's stop bit is on the line.
   task automatic frame_done(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok)                 exp_fe++;
      else if (exp_q.size() == DEPTH) exp_ov++;
      else                          exp_q.push_back(b);
   endtask

   // Caller is always just after a rising edge; each bit lasts CPB clocks.
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      rx = stop_ok;
      repeat (2) @(posedge clk);
      #1;
      frame_done(b, stop_ok);
      repeat (CPB - 2) @(posedge clk);
      #1;
   endtask

   // Per-cycle monitor, sampling on the falling edge.
   logic        prev_stb  = 1'b0;
   logic        prev_ack  = 1'b0;
   logic        prev_fe   = 1'b0;
   logic        prev_ov   = 1'b0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         check("reset_stb", {31'd0, sif.output_rx_stb}, 32'd0);
         check("reset_data", sif.output_rx, 32'd0);
         check("reset_fe", {31'd0, framing_error}, 32'd0);
         check("reset_ov", {31'd0, overrun}, 32'd0);
         prev_stb = 1'b0;
         prev_ack = 1'b0;
         prev_fe  = 1'b0;
         prev_ov  = 1'b0;
      end else begin
         if (framing_error) begin
            obs_fe++;
            check("fe_single_cycle", {31'd0, prev_fe}, 32'd0);
         end
         if (overrun) begin
            obs_ov++;
            last_ov_cyc = cyc;
            check("ov_single_cycle", {31'd0, prev_ov}, 32'd0);
         end
         if (sif.output_rx_stb) begin
            stb_cycles++;
            check("upper_bits_zero", {8'd0, sif.output_rx[31:8]}, 32'd0);
         end else begin
            check("idle_data_zero", sif.output_rx, 32'd0);
         end
         if (prev_stb && !prev_ack) begin
            check("held_stb", {31'd0, sif.output_rx_stb}, 32'd1);
            check("held_data", sif.output_rx, prev_data);
         end
         if (latency_armed && sif.output_rx_stb && !prev_stb) begin
            check("first_stb_latency", cyc - start_cyc, 32'd155);
            latency_armed = 1'b0;
         end
         if (sif.output_rx_stb && sif.output_rx_ack) begin
            got_q.push_back(sif.output_rx[7:0]);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%08h expected none", sif.output_rx);
            end else begin
               check("stream_byte", sif.output_rx, {24'd0, exp_q.pop_front()});
            end
         end
         prev_stb  = sif.output_rx_stb;
         prev_ack  = sif.output_rx_ack;
         prev_fe   = framing_error;
         prev_ov   = overrun;
         prev_data = sif.output_rx;
      end
   end

   int base_stb;
   int base_got;

   initial begin
      sif.output_rx_ack = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_bits(2);

      // 1: 0x55 with ack high, one stb cycle, latency pinned
      sif.output_rx_ack = 1'b1;
      base_stb = stb_cycles;
      latency_armed = 1'b1;
      send_byte(8'h55, 1'b1);
      idle_bits(2);
      check("t1_stb_cycles", stb_cycles - base_stb, 32'd1);
      check("t1_byte", {24'd0, got_q[got_q.size()-1]}, 32'h55);
      check("t1_latency_seen", {31'd0, latency_armed}, 32'd0);
      check("t1_no_fe", obs_fe, 32'd0);

      // 2: 0xA3 held for 100 cycles with ack low
      sif.output_rx_ack = 1'b0;
      send_byte(8'hA3, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      check("t2_stb_held", {31'd0, sif.output_rx_stb}, 32'd1);
      check("t2_data_held", sif.output_rx, 32'h0000_00A3);
      sif.output_rx_ack = 1'b1;
      @(posedge clk);
      #1;
      check("t2_stb_drop", {31'd0, sif.output_rx_stb}, 32'd0);
      idle_bits(1);

      // 3: 4-cycle glitch rejected, then 0x12
      base_stb = stb_cycles;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      idle_bits(2);
      check("t3_glitch_no_stb", stb_cycles - base_stb, 32'd0);
      check("t3_glitch_no_fe", obs_fe, 32'd0);
      send_byte(8'h12, 1'b1);
      idle_bits(2);
      check("t3_byte", {24'd0, got_q[got_q.size()-1]}, 32'h12);

      // 4: framing error, held break, then 0x7E
      base_got = got_q.size();
      send_byte(8'h00, 1'b0);
      repeat (20 * CPB) @(posedge clk);
      #1;
      check("t4_fe_count", obs_fe, 32'd1);
      check("t4_no_bad_byte", got_q.size() - base_got, 32'd0);
      rx = 1'b1;
      idle_bits(2);
      check("t4_fe_still_one", obs_fe, 32'd1);
      send_byte(8'h7E, 1'b1);
      idle_bits(2);
      check("t4_byte", {24'd0, got_q[got_q.size()-1]}, 32'h7E);

      // 5: overrun on the fifth byte with ack low
      sif.output_rx_ack = 1'b0;
      base_got = got_q.size();
      for (int i = 1; i <= 5; i++) begin
         send_byte(8'(i), 1'b1);
         idle_bits(1);
      end
      check("t5_ov_count", obs_ov, 32'd1);
      check("t5_ov_on_5th_stop", last_ov_cyc - start_cyc, 32'd155);
      sif.output_rx_ack = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("t5_pop_count", got_q.size() - base_got, 32'd4);
      for (int i = 0; i < 4; i++)
         check("t5_pop_order", {24'd0, got_q[base_got + i]}, 32'(i + 1));
      check("t5_stb_low", {31'd0, sif.output_rx_stb}, 32'd0);

      // 6: reset during bit 3 of 0xFF, then 0x3C
      base_got = got_q.size();
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      repeat (CPB / 2) @(posedge clk);
      #1;
      rst = 1'b1;
      rx  = 1'b1;
      exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_bits(2);
      check("t6_no_partial", got_q.size() - base_got, 32'd0);
      send_byte(8'h3C, 1'b1);
      idle_bits(2);
      check("t6_one_byte", got_q.size() - base_got, 32'd1);
      check("t6_byte", {24'd0, got_q[got_q.size()-1]}, 32'h3C);

      // Model-vs-observed totals
      check("total_fe", obs_fe, exp_fe);
      check("total_ov", obs_ov, exp_ov);
      check("all_delivered", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
